// File: rtl/mp_add_seq.sv
// mp_add_seq: sequential multi-precision adder.
//   Two NUM_WORDS-word operands arrive as a stream of DATA_WIDTH-bit word
//   pairs, least-significant word first. Each pair is added with the carry
//   of the previous word, and one registered sum word is produced per
//   accepted pair (1-cycle latency, full throughput).
//
// Optional build macro: MP_ADD_SUB_EN
//   Adds the in_sub port. The value on word 0 is latched for the whole
//   operand; when set, the block computes A-B modulo 2^(DATA_WIDTH*NUM_WORDS).
//   In that case the final out_carry=1 means there was no borrow (A>=B).
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   input word pair valid
//   in_ready   input accepted this cycle (combinational: !out_valid || out_ready)
//   in_a/in_b  operand words
//   in_sub     (MP_ADD_SUB_EN only) subtract select, sampled on word 0
//   out_valid  output word valid
//   out_ready  consumer accepts the output word
//   out_sum    sum word
//   out_last   output is the final word of the operand
//   out_carry  carry-out of this word (final operand carry when out_last=1)

module mp_add_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
`ifdef MP_ADD_SUB_EN
  input  logic                  in_sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic                  out_last,
  output logic                  out_carry
);

  localparam int unsigned CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned SW = DATA_WIDTH + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         wcnt_q, wcnt_d;
  logic                  carry_q, carry_d;
  logic                  out_valid_d;
  logic [DATA_WIDTH-1:0] out_sum_d;
  logic                  out_last_d;
  logic                  out_carry_d;

  logic                  accept;
  logic                  first_word;
  logic                  last_word;
  logic                  cin;
  logic [DATA_WIDTH-1:0] b_eff;
  logic [SW-1:0]         sum_full;

`ifdef MP_ADD_SUB_EN
  logic                  sub_q, sub_d;
  logic                  sub_cur;
`endif

  // Ready only depends on the output register being free or draining.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Word adder: IDLE means the next accepted beat is word 0.
  always_comb begin
    first_word = (state_q == IDLE);
    last_word  = (wcnt_q == LAST_IDX);
`ifdef MP_ADD_SUB_EN
    // Word 0 takes in_sub directly; later words use the latched flag.
    sub_cur = first_word ? in_sub : sub_q;
    b_eff   = sub_cur ? ~in_b : in_b;
    cin     = first_word ? sub_cur : carry_q;
`else
    b_eff   = in_b;
    cin     = first_word ? 1'b0 : carry_q;
`endif
    sum_full = SW'(in_a) + SW'(b_eff) + SW'(cin);
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    carry_d     = carry_q;
    out_valid_d = out_valid;
    out_sum_d   = out_sum;
    out_last_d  = out_last;
    out_carry_d = out_carry;
`ifdef MP_ADD_SUB_EN
    sub_d       = sub_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = last_word ? IDLE : BUSY;
        end
      end
      BUSY: begin
        if (accept && last_word) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      out_valid_d = 1'b1;
      out_sum_d   = sum_full[DATA_WIDTH-1:0];
      out_carry_d = sum_full[DATA_WIDTH];
      out_last_d  = last_word;
      // Wrapping the counter also clears the carry so operands stay independent.
      if (last_word) begin
        wcnt_d  = '0;
        carry_d = 1'b0;
      end else begin
        wcnt_d  = wcnt_q + CW'(1);
        carry_d = sum_full[DATA_WIDTH];
      end
`ifdef MP_ADD_SUB_EN
      if (first_word) begin
        sub_d = in_sub;
      end
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      carry_q   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_carry <= 1'b0;
`ifdef MP_ADD_SUB_EN
      sub_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      carry_q   <= carry_d;
      out_valid <= out_valid_d;
      out_sum   <= out_sum_d;
      out_last  <= out_last_d;
      out_carry <= out_carry_d;
`ifdef MP_ADD_SUB_EN
      sub_q     <= sub_d;
`endif
    end
  end

endmodule

// File: tb/tb_mp_add_seq.sv
// Testbench for mp_add_seq (DATA_WIDTH=8, NUM_WORDS=4): directed vector table,
// backpressure and mid-operand reset sequences, and gapped random traffic
// checked by an operand-level arithmetic scoreboard.

module tb_mp_add_seq;

  localparam int unsigned DW = 8;
  localparam int unsigned NW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_sum;
  logic          out_last;
  logic          out_carry;

  int tests = 0;
  int fails = 0;

  mp_add_seq #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
`ifdef MP_ADD_SUB_EN
    .in_sub   (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_last (out_last),
    .out_carry(out_carry)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected word i of an operand comes from adding the
  // low (i+1) words of A and B as plain integers.
  typedef struct {
    logic [DW-1:0] sum;
    logic          carry;
    logic          last;
  } exp_t;

  exp_t        exp_q[$];
  int          idx;
  logic [63:0] acc_a, acc_b;
  logic        sub_l;

  initial begin
    exp_t        e;
    int          w;
    logic [63:0] mask, bv, p;
    idx = 0; acc_a = '0; acc_b = '0; sub_l = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        idx = 0; acc_a = '0; acc_b = '0; sub_l = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_output", 64'(out_sum), 64'hdead);
          end else begin
            e = exp_q.pop_front();
            check("sb_sum", 64'(out_sum), 64'(e.sum));
            check("sb_carry", 64'(out_carry), 64'(e.carry));
            check("sb_last", 64'(out_last), 64'(e.last));
          end
        end
        if (in_valid && in_ready) begin
          if (idx == 0) begin
            acc_a = '0; acc_b = '0; sub_l = sub;
          end
          acc_a = acc_a | (64'(in_a) << (DW * idx));
          acc_b = acc_b | (64'(in_b) << (DW * idx));
          w     = DW * (idx + 1);
          mask  = (64'd1 << w) - 64'd1;
          bv    = sub_l ? (~acc_b & mask) : acc_b;
          p     = acc_a + bv + 64'(sub_l);
          e.sum   = DW'(p >> (DW * idx));
          e.carry = p[w];
          e.last  = (idx == NW - 1);
          exp_q.push_back(e);
          idx = (idx + 1) % NW;
        end
      end
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] sums;
    logic [3:0]  carries;
  } vec_t;

  // Drives one operand back to back and checks each output directly.
  task automatic run_vector(input string name, input vec_t v);
    for (int i = 0; i < NW; i++) begin
      in_valid = 1'b1;
      in_a     = v.a[DW*i +: DW];
      in_b     = v.b[DW*i +: DW];
      sub      = (i == 0) ? v.sub : 1'($urandom);
      @(posedge clk); #1;
      check({name, "_valid"}, 64'(out_valid), 64'd1);
      check({name, "_sum"}, 64'(out_sum), 64'(v.sums[DW*i +: DW]));
      check({name, "_carry"}, 64'(out_carry), 64'(v.carries[i]));
      check({name, "_last"}, 64'(out_last), 64'(i == NW - 1));
    end
  endtask

  initial begin
    vec_t        vecs[$];
    vec_t        v;
    logic [DW-1:0] bp_a[NW];
    logic [DW-1:0] bp_b[NW];
    logic [DW-1:0] bp_s[NW];
    logic          bp_c[NW];
    int          beats;
    int          cycles;
    logic        acc;

    // {a, b, sub, sums (word3..word0), carries (bit i = word i)}
    vecs.push_back('{32'h00FFFFFF, 32'h00000001, 1'b0, 32'h01000000, 4'b0111});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 4'b1111});
    vecs.push_back('{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000});
    vecs.push_back('{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 4'b0011});
    vecs.push_back('{32'h01020304, 32'h01010101, 1'b0, 32'h02030405, 4'b0000});
`ifdef MP_ADD_SUB_EN
    vecs.push_back('{32'h00000001, 32'h00000002, 1'b1, 32'hFFFFFFFF, 4'b0000});
    vecs.push_back('{32'h00000005, 32'h00000003, 1'b1, 32'h00000002, 4'b1111});
`endif

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(out_sum), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_carry", 64'(out_carry), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    // Table: all operands back to back, no bubbles between them.
    foreach (vecs[k]) run_vector($sformatf("vec%0d", k), vecs[k]);
    in_valid = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    check("idle_valid", 64'(out_valid), 64'd0);

    // Backpressure in the middle of a carry ripple.
    bp_a = '{8'hFF, 8'hFF, 8'hFF, 8'h00};
    bp_b = '{8'h01, 8'h00, 8'h00, 8'h00};
    bp_s = '{8'h00, 8'h00, 8'h00, 8'h01};
    bp_c = '{1'b1, 1'b1, 1'b1, 1'b0};
    in_valid = 1'b1; in_a = bp_a[0]; in_b = bp_b[0];
    @(posedge clk); #1;
    check("bp_w0_sum", 64'(out_sum), 64'(bp_s[0]));
    out_ready = 1'b0; in_a = bp_a[1]; in_b = bp_b[1];
    #1;
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_sum", 64'(out_sum), 64'(bp_s[0]));
      check("bp_hold_carry", 64'(out_carry), 64'(bp_c[0]));
      check("bp_hold_last", 64'(out_last), 64'd0);
      check("bp_hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'd1);
    for (int i = 1; i < NW; i++) begin
      in_a = bp_a[i]; in_b = bp_b[i];
      @(posedge clk); #1;
      check("bp_sum", 64'(out_sum), 64'(bp_s[i]));
      check("bp_carry", 64'(out_carry), 64'(bp_c[i]));
      check("bp_last", 64'(out_last), 64'(i == NW - 1));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset after three words of an operand discards it.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22;
      @(posedge clk); #1;
    end
    rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_sum", 64'(out_sum), 64'd0);
    check("mrst_last", 64'(out_last), 64'd0);
    check("mrst_carry", 64'(out_carry), 64'd0);
    rst_n = 1'b1;
    v = '{32'h01020304, 32'h01010101, 1'b0, 32'h02030405, 4'b0000};
    run_vector("post_rst", v);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Gapped random traffic: in_valid toggles, out_ready random.
    beats = 0; cycles = 0; in_valid = 1'b0;
    while (beats < 1000 * NW && cycles < 40000) begin
      in_valid  = ~in_valid;
      in_a      = DW'($urandom);
      in_b      = DW'($urandom);
`ifdef MP_ADD_SUB_EN
      sub       = 1'($urandom);
`else
      sub       = 1'b0;
`endif
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) beats++;
      cycles++;
    end
    check("rand_beats_done", 64'(beats), 64'(1000 * NW));
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("sb_drain_empty", 64'(exp_q.size()), 64'd0);
    check("sb_operand_aligned", 64'(idx), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
- Sequential multi-precision adder.
- Accepts two NUM_WORDS-word operands as a stream of DATA_WIDTH-bit word pairs, least-significant word first.
- Adds each pair with the carry from the previous word and streams out registered sum words, flagging the final word and the final carry-out.
- Sits upstream of the word-level adder/reduction stages so that operands wider than DATA_WIDTH can be summed in the GF/integer datapath.

Parameters:
DATA_WIDTH, 32, bits per word of each operand and of the sum.
NUM_WORDS, 4, words per operand (>=2); full operand width is DATA_WIDTH*NUM_WORDS.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  word pair on in_a/in_b is valid.
in_ready  output  1  block accepts the word pair this cycle.
in_a  input  DATA_WIDTH  operand A word.
in_b  input  DATA_WIDTH  operand B word.
out_valid  output  1  out_sum/out_last/out_carry are valid.
out_ready  input  1  consumer accepts the output word.
out_sum  output  DATA_WIDTH  sum word.
out_last  output  1  the current output is word NUM_WORDS-1 of the operand.
out_carry  output  1  carry-out of the current output word; the final operand carry when out_last=1.

Behaviour:
- Reset: clk is the only clock; rst_n is synchronous and active-low. When rst_n=0 at a rising edge: out_valid=0, out_sum=0, out_last=0, out_carry=0, word counter=0, carry register=0, state=IDLE. Reset mid-operand discards the partial result; the next accepted beat is word 0.
- Handshake: a beat transfers when valid and ready are both high.
  - in_ready = !out_valid || out_ready. It is combinational from out_ready, with no dependency on in_valid.
  - out_* are held stable while out_valid=1 and out_ready=0.
- Latency: 1 cycle. The sum of an input beat accepted at edge N is presented on out_* after edge N, so full throughput is 1 word per cycle.
- Arithmetic: {c, s} = in_a + in_b + cin (DATA_WIDTH+1 bits).
  - cin = 0 for word 0; otherwise cin = the carry register.
  - On accept: out_sum<=s, out_carry<=c, carry register<=c.
- Counter: wcnt, ceil(log2(NUM_WORDS)) bits, increments on each accepted beat.
  - At NUM_WORDS-1 it wraps to 0 and the carry register clears, so no carry leaks into the next operand.
  - out_last <= (wcnt==NUM_WORDS-1) on accept.
- FSM:
  - IDLE (wcnt=0, no operand in flight) -> BUSY on accept of word 0.
  - BUSY -> BUSY on accept of words 1..NUM_WORDS-2.
  - BUSY -> IDLE on accept of word NUM_WORDS-1.
  - A new operand may begin in the cycle immediately after the last word; there are no bubbles.
- Output register:
  - If an accept occurs, out_valid<=1 and the data loads.
  - Else if out_ready=1, out_valid<=0.
  - Simultaneous output drain and input accept in the same cycle keeps out_valid=1 with the new data.
- No input consumed while out_valid=1 and out_ready=0 (backpressure propagates).

Optional Feature:
MP_ADD_SUB_EN:
- Defined:
  - Adds port in_sub (input, 1), sampled with word 0 and latched for the whole operand; its values on words 1..N-1 are ignored.
  - When latched sub=1, in_b is bitwise inverted and cin for word 0 = 1, computing A-B mod 2^(DATA_WIDTH*NUM_WORDS).
  - out_carry on the last word = 1 means no borrow (A>=B).
  - The latched sub flag resets to 0.
- Undefined: no in_sub port; addition only.

Test Plan:
- Add with carry ripple: DATA_WIDTH=8, NUM_WORDS=4, out_ready=1, A=0x00FFFFFF, B=0x00000001, 4 back-to-back beats -> out_sum 0x00,0x00,0x00,0x01; out_carry 1,1,1,0; out_last only on beat 4.
- Overflow and no leak between operands: A=B=0xFFFFFFFF then A=B=0x00000000 back to back -> first operand sums 0xFE,0xFF,0xFF,0xFF with final out_carry=1; second operand sums all 0x00, out_carry=0 (carry cleared at wrap).
- Backpressure: hold out_ready=0 for 3 cycles after first output -> in_ready=0, out_sum/out_last/out_carry unchanged; on release, stream continues with correct carry and no word dropped or duplicated.
- Reset mid-operand: assert rst_n=0 after word 2 -> next cycle out_valid=0, all outputs 0; new operand A=0x01020304, B=0x01010101 -> sums 0x05,0x04,0x03,0x02, out_last on 4th.
- Gapped input: in_valid toggling 1/0 each cycle with random out_ready; check against a reference 32-bit sum over 1000 operands.
- (MP_ADD_SUB_EN) A=0x00000001, B=0x00000002, in_sub=1 -> sums 0xFF,0xFF,0xFF,0xFF, final out_carry=0 (borrow); A=5, B=3 -> 0x02,0x00,0x00,0x00, final out_carry=1.
